// File: rtl/jam_pkg.sv
// Shared types and elaboration helpers for the job-assignment solver.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    CMP,
    FIND,
    SWAP,
    REV,
    DONE
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint unsigned factorial(input int n);
    longint unsigned f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Permutation register and lexicographic next-permutation engine.
module jam_perm_next
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          init,
  input  logic          step,
  output logic          next_done,
  output logic          last,
  output logic [N*IW-1:0] perm
);

  localparam logic [IW-1:0] TOP = IW'(N - 1);

  state_t ph_q;
  logic [IW-1:0] i_q, j_q, lo_q, hi_q, piv_q;
  logic [N*IW-1:0] perm_q;
  logic hit;

  function automatic logic [N*IW-1:0] ident();
    logic [N*IW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*IW +: IW] = IW'(k);
    return p;
  endfunction

  function automatic logic [IW-1:0] at(
    input logic [N*IW-1:0] p,
    input logic [IW-1:0]   k
  );
    return p[k*IW +: IW];
  endfunction

  assign perm = perm_q;
  assign hit  = at(perm_q, i_q) < at(perm_q, i_q + IW'(1));

  always_comb begin
    next_done = (ph_q == REV) && (lo_q >= hi_q);
    last      = (ph_q == FIND) && !hit && (i_q == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph_q   <= IDLE;
      perm_q <= ident();
      i_q    <= '0;
      j_q    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      piv_q  <= '0;
    end else if (init) begin
      ph_q   <= IDLE;
      perm_q <= ident();
    end else begin
      unique case (ph_q)
        IDLE: begin
          if (step) begin
            ph_q <= FIND;
            i_q  <= IW'(N - 2);
          end
        end
        FIND: begin
          if (hit) begin
            piv_q <= i_q;
            j_q   <= TOP;
            ph_q  <= SWAP;
          end else if (i_q == '0) begin
            ph_q <= IDLE;
          end else begin
            i_q <= i_q - IW'(1);
          end
        end
        SWAP: begin
          if (at(perm_q, j_q) > at(perm_q, piv_q)) begin
            perm_q[piv_q*IW +: IW] <= at(perm_q, j_q);
            perm_q[j_q*IW +: IW]   <= at(perm_q, piv_q);
            lo_q <= piv_q + IW'(1);
            hi_q <= TOP;
            ph_q <= REV;
          end else begin
            j_q <= j_q - IW'(1);
          end
        end
        REV: begin
          if (lo_q >= hi_q) begin
            ph_q <= IDLE;
          end else begin
            perm_q[lo_q*IW +: IW] <= at(perm_q, hi_q);
            perm_q[hi_q*IW +: IW] <= at(perm_q, lo_q);
            lo_q <= lo_q + IW'(1);
            hi_q <= hi_q - IW'(1);
          end
        end
        default: ph_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jam_solver_p.sv
// Exhaustive job-assignment solver: walks all N! permutations,
// tracking the min/max total, its multiplicity and first optimum.
module jam_solver_p
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int CW    = 7,
  parameter int IW    = 3,
  parameter int SW    = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Mode,
  output logic [IW-1:0]    W,
  output logic [IW-1:0]    J,
  input  logic [CW-1:0]    Cost,
  output logic             Busy,
  output logic [SW-1:0]    MinCost,
  output logic [CNT_W-1:0] MatchCount,
  output logic [N*IW-1:0]  BestPerm,
  output logic             Valid
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("N must be 2..8");
  end
  if ((1 << IW) < N) begin : g_bad_iw
    $error("IW too narrow for N");
  end
  if (SW < CW + clog2(N)) begin : g_bad_sw
    $error("SW too narrow for N*Cost");
  end
  if ((longint'(1) << CNT_W) <= factorial(N)) begin : g_bad_cnt
    $error("CNT_W too narrow for N!");
  end

  localparam logic [IW-1:0] KLAST = IW'(N - 1);

  state_t state_q, state_d;
  logic mode_q;
  logic [IW-1:0] k_q;
  logic [SW-1:0] acc_q;
  logic [N*IW-1:0] perm;
  logic go, step, next_done, last, better;

  assign Busy  = (state_q == EVAL) || (state_q == CMP) || (state_q == FIND);
  assign Valid = (state_q == DONE);
  assign go    = Start && !Busy;
  assign step  = (state_q == CMP);
  assign W     = (state_q == EVAL) ? k_q : '0;
  assign J     = (state_q == EVAL) ? perm[k_q*IW +: IW] : '0;

  assign better = (mode_q == MODE_MAX) ? (acc_q > MinCost)
                                       : (acc_q < MinCost);

  jam_perm_next #(
    .N (N),
    .IW(IW)
  ) u_next (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .init     (go),
    .step     (step),
    .next_done(next_done),
    .last     (last),
    .perm     (perm)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FIND here spans the whole engine walk (find, swap, reverse).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (go) state_d = EVAL;
      EVAL:       if (k_q == KLAST) state_d = CMP;
      CMP:        state_d = FIND;
      FIND: begin
        if (last)           state_d = DONE;
        else if (next_done) state_d = EVAL;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q     <= MODE_MIN;
      k_q        <= '0;
      acc_q      <= '0;
      MinCost    <= '1;
      MatchCount <= '0;
      BestPerm   <= '0;
    end else begin
      if (go) begin
        mode_q     <= Mode;
        MinCost    <= (Mode == MODE_MIN) ? '1 : '0;
        MatchCount <= '0;
        k_q        <= '0;
        acc_q      <= '0;
      end
      if (state_q == EVAL) begin
        acc_q <= acc_q + SW'(Cost);
        k_q   <= k_q + IW'(1);
      end
      if (state_q == CMP) begin
        if (better) begin
          MinCost    <= acc_q;
          MatchCount <= CNT_W'(1);
          BestPerm   <= perm;
        end else if (acc_q == MinCost) begin
          MatchCount <= MatchCount + CNT_W'(1);
        end
      end
      if (state_q == FIND && next_done) begin
        k_q   <= '0;
        acc_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jam_solver_p.sv
// Bench for jam_solver_p: N=3, N=2, N=6 full runs and N=8 ordering.
module tb_jam_solver_p;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int cm3 [8][8];

  logic s3, m3, b3, v3;
  logic [2:0] w3, j3;
  logic [6:0] c3;
  logic [9:0] mc3;
  logic [15:0] n3;
  logic [8:0] bp3;

  logic s2, m2, b2, v2;
  logic [2:0] w2, j2;
  logic [9:0] mc2;
  logic [15:0] n2;
  logic [5:0] bp2;

  logic s6, m6, b6, v6;
  logic [2:0] w6, j6;
  logic [9:0] mc6;
  logic [15:0] n6;
  logic [17:0] bp6;

  logic s8, m8, b8, v8;
  logic [2:0] w8, j8;
  logic [9:0] mc8;
  logic [15:0] n8;
  logic [23:0] bp8;

  assign c3 = 7'(cm3[w3][j3]);

  jam_solver_p #(.N(3)) u3 (
    .CLK(CLK), .RST_N(RST_N), .Start(s3), .Mode(m3),
    .W(w3), .J(j3), .Cost(c3), .Busy(b3), .MinCost(mc3),
    .MatchCount(n3), .BestPerm(bp3), .Valid(v3)
  );
  jam_solver_p #(.N(2)) u2 (
    .CLK(CLK), .RST_N(RST_N), .Start(s2), .Mode(m2),
    .W(w2), .J(j2), .Cost(7'd3), .Busy(b2), .MinCost(mc2),
    .MatchCount(n2), .BestPerm(bp2), .Valid(v2)
  );
  jam_solver_p #(.N(6)) u6 (
    .CLK(CLK), .RST_N(RST_N), .Start(s6), .Mode(m6),
    .W(w6), .J(j6), .Cost(7'd10), .Busy(b6), .MinCost(mc6),
    .MatchCount(n6), .BestPerm(bp6), .Valid(v6)
  );
  jam_solver_p #(.N(8)) u8 (
    .CLK(CLK), .RST_N(RST_N), .Start(s8), .Mode(m8),
    .W(w8), .J(j8), .Cost(7'd10), .Busy(b8), .MinCost(mc8),
    .MatchCount(n8), .BestPerm(bp8), .Valid(v8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: scan every n-digit tuple in increasing order and keep
  // the ones that are permutations, which yields lexicographic order.
  task automatic model(input int n, input bit mx, input int cst,
                       output longint bc, output longint cnt,
                       output longint bp);
    int pw;
    int d [8];
    bit first;
    pw = 1;
    for (int k = 0; k < n; k++) pw *= n;
    bc = 0; cnt = 0; bp = 0; first = 1;
    for (int t = 0; t < pw; t++) begin
      int x;
      int used;
      bit ok;
      int s;
      longint p;
      x = t; used = 0; ok = 1; s = 0; p = 0;
      for (int k = n - 1; k >= 0; k--) begin
        d[k] = x % n;
        x = x / n;
      end
      for (int k = 0; k < n; k++) begin
        if (used[d[k]]) ok = 0;
        used = used | (1 << d[k]);
        s += (cst < 0) ? cm3[k][d[k]] : cst;
        p = p | (longint'(d[k]) << (3 * k));
      end
      if (ok) begin
        if (first || (mx ? (s > bc) : (s < bc))) begin
          bc = s; cnt = 1; bp = p; first = 0;
        end else if (s == bc) begin
          cnt++;
        end
      end
    end
  endtask

  bit arm3 = 0;
  longint e3c, e3n, e3p;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (b3 || v3) chk("u3_busy_valid_excl", longint'(b3 && v3), 0);
      if (arm3 && v3) begin
        chk("u3_mincost", mc3, e3c);
        chk("u3_count", n3, e3n);
        chk("u3_bestperm", bp3, e3p);
      end
    end
  end

  function automatic bit vld(input int which);
    case (which)
      3: return v3;
      2: return v2;
      6: return v6;
      default: return v8;
    endcase
  endfunction

  task automatic wait_v(input int which, input int budget);
    int c;
    c = 0;
    while (!vld(which) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    if (!vld(which)) begin
      failures++;
      checks++;
      $display("FAIL wait_valid_u%0d: got timeout want Valid", which);
    end
  endtask

  task automatic start3(input bit md);
    @(negedge CLK);
    m3 = md; s3 = 1'b1;
    @(negedge CLK);
    s3 = 1'b0;
  endtask

  task automatic run3(input bit md);
    arm3 = 0;
    model(3, md, -1, e3c, e3n, e3p);
    start3(md);
    wait_v(3, 400);
    chk("u3_busy_at_valid", b3, 0);
    arm3 = 1;
    repeat (3) @(negedge CLK);
    arm3 = 0;
  endtask

  longint bc, cn, bp;
  int ws[$], js[$];
  int wins[$];
  int ea [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int eb [8] = '{0, 1, 2, 3, 4, 5, 7, 6};

  initial begin
    int row0 [3] = '{5, 1, 9};
    int row1 [3] = '{2, 7, 3};
    int row2 [3] = '{8, 4, 6};
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) cm3[w][j] = 0;
    for (int j = 0; j < 3; j++) begin
      cm3[0][j] = row0[j];
      cm3[1][j] = row1[j];
      cm3[2][j] = row2[j];
    end
    {s3, m3, s2, m2, s6, m6, s8, m8} = '0;

    repeat (3) @(negedge CLK);
    chk("rst_busy", b3, 0);
    chk("rst_valid", v3, 0);
    chk("rst_mincost", mc3, 1023);
    chk("rst_count", n3, 0);
    chk("rst_bestperm", bp3, 0);
    chk("rst_w", w3, 0);
    chk("rst_j", j3, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_valid", v3, 0);

    model(3, 0, -1, bc, cn, bp);
    chk("model_min_cost", bc, 9);
    chk("model_min_count", cn, 1);
    chk("model_min_perm", bp, 129);
    model(3, 1, -1, bc, cn, bp);
    chk("model_max_cost", bc, 24);
    chk("model_max_count", cn, 1);
    chk("model_max_perm", bp, 10);

    run3(0);
    run3(1);

    // abort during EVAL of the fourth permutation (1,2,0)
    start3(0);
    repeat (24) @(posedge CLK);
    #1;
    chk("perm4_w", w3, 1);
    chk("perm4_j", j3, 2);
    RST_N = 1'b0;
    #1;
    chk("abort_busy", b3, 0);
    chk("abort_valid", v3, 0);
    chk("abort_mincost", mc3, 1023);
    chk("abort_count", n3, 0);
    chk("abort_bestperm", bp3, 0);
    chk("abort_w", w3, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("post_abort_valid", v3, 0);
    chk("post_abort_busy", b3, 0);
    run3(0);

    // Start while busy is ignored
    arm3 = 0;
    model(3, 0, -1, e3c, e3n, e3p);
    start3(0);
    repeat (4) @(negedge CLK);
    start3(1);
    chk("busy_during_run", b3, 1);
    wait_v(3, 400);
    arm3 = 1;
    repeat (3) @(negedge CLK);
    arm3 = 0;
    model(3, 1, -1, e3c, e3n, e3p);
    start3(1);
    chk("restart_valid_drop", v3, 0);
    chk("restart_busy", b3, 1);
    wait_v(3, 400);
    arm3 = 1;
    repeat (3) @(negedge CLK);
    arm3 = 0;

    // N=2, all costs 3
    model(2, 0, 3, bc, cn, bp);
    chk("model2_cost", bc, 6);
    chk("model2_count", cn, 2);
    chk("model2_perm", bp, 8);
    @(negedge CLK);
    m2 = 0; s2 = 1;
    @(negedge CLK);
    s2 = 0;
    wait_v(2, 200);
    chk("u2_mincost", mc2, bc);
    chk("u2_count", n2, cn);
    chk("u2_bestperm", bp2, bp);

    // N=6, all costs 10
    model(6, 0, 10, bc, cn, bp);
    chk("model6_cost", bc, 60);
    chk("model6_count", cn, 720);
    @(negedge CLK);
    m6 = 0; s6 = 1;
    @(negedge CLK);
    s6 = 0;
    wait_v(6, 30000);
    chk("u6_mincost", mc6, bc);
    chk("u6_count", n6, cn);
    chk("u6_bestperm", bp6, bp);

    // N=8: index sequence of the first two permutations
    @(negedge CLK);
    m8 = 0; s8 = 1;
    @(negedge CLK);
    s8 = 0;
    for (int i = 0; i < 30; i++) begin
      ws.push_back(int'(w8));
      js.push_back(int'(j8));
      @(negedge CLK);
    end
    chk("u8_busy", b8, 1);
    for (int t = 0; t + 8 <= 30; t++) begin
      bit ok;
      ok = 1;
      for (int k = 0; k < 8; k++) if (ws[t+k] != k) ok = 0;
      if (ok) wins.push_back(t);
    end
    chk("u8_windows_ge2", longint'(wins.size() >= 2), 1);
    if (wins.size() >= 2) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("u8_p0_j%0d", k), js[wins[0]+k], ea[k]);
        chk($sformatf("u8_p1_j%0d", k), js[wins[1]+k], eb[k]);
      end
    end
    RST_N = 1'b0;
    #1;
    chk("u8_abort_busy", b8, 0);
    chk("u8_abort_count", n8, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
